// File: rtl/fdivsqrt_sched_pkg.sv
// Shared types and constants for the divide/sqrt iteration scheduler.
package fdivsqrt_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NF_SINGLE = 23;
    localparam int NF_DOUBLE = 52;
    localparam int NF_HALF   = 10;
    localparam int NF_QUAD   = 112;

    localparam int LOGR_DEF       = 2;
    localparam int DIVCOPIES_DEF  = 4;
    localparam int BITS_PER_CYCLE = LOGR_DEF * DIVCOPIES_DEF;

    // Fraction width for the FP format code (00 single, 01 double, 10 half, 11 quad).
    function automatic int nf_of(input logic [1:0] fmt);
        case (fmt)
            2'b00:   return NF_SINGLE;
            2'b01:   return NF_DOUBLE;
            2'b10:   return NF_HALF;
            default: return NF_QUAD;
        endcase
    endfunction

endpackage

// File: rtl/fdivsqrt_itercount.sv
// Iteration count for one divide/sqrt operation; purely combinational so a
// latency predictor can reuse it.
module fdivsqrt_itercount
    import fdivsqrt_sched_pkg::*;
#(
    parameter int BPC     = BITS_PER_CYCLE,
    parameter int XLEN    = 64,
    parameter int LOGXLEN = 6,
    parameter int CNTW    = 5
) (
    input  logic [1:0]       FmtE,
    input  logic             SpecialCaseE,
    input  logic [LOGXLEN:0] IntnE,
    input  logic             IsInt,
    output logic [CNTW-1:0]  NIter
);

    int bits;

    always_comb begin
        if (IsInt) begin
            bits = 32'(IntnE) + 1;
            // an integer quotient never carries more than XLEN bits
            if (bits > XLEN) bits = XLEN;
        end else begin
            bits = nf_of(FmtE) + 4;
        end
        NIter = CNTW'((bits + BPC - 1) / BPC);
        if (!IsInt && SpecialCaseE) NIter = '0;
    end

endmodule

// File: rtl/fdivsqrt_sched.sv
// Scheduler for the shared radix-4 divide/sqrt datapath: round-robin grant,
// iteration sequencing, done held until acknowledged, flush abort.
//   state | meaning
//   IDLE  | no operation; a pending request is granted this cycle
//   BUSY  | iterating; IterCnt holds the remaining iterations
//   DONE  | result ready, datapath frozen until ResultAckE
module fdivsqrt_sched
    import fdivsqrt_sched_pkg::*;
#(
    parameter int DIVCOPIES = DIVCOPIES_DEF,
    parameter int LOGR      = LOGR_DEF,
    parameter int XLEN      = 64,
    parameter int LOGXLEN   = 6,
    parameter int CNTW      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             FDivReqE,
    input  logic [1:0]       FmtE,
    input  logic             SqrtE,
    input  logic             SpecialCaseE,
    input  logic             IDivReqE,
    input  logic [LOGXLEN:0] IntnE,
    input  logic             FlushE,
    input  logic             ResultAckE,
    output logic             IFDivStartE,
    output logic             FDivBusyE,
    output logic             FpGntE,
    output logic             IntGntE,
    output logic             DivDoneM,
    output logic             DoneIsIntM,
    output logic             DoneSqrtM,
    output logic [CNTW-1:0]  IterCnt
);

    localparam int BPC = LOGR * DIVCOPIES;

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            rr_fp_q, rr_fp_d;
    logic            owner_int_q, owner_int_d;
    logic            sqrt_q, sqrt_d;
    logic            gnt_any, pick_int;
    logic [CNTW-1:0] n_iter;

    assign gnt_any  = (state_q == IDLE) && !reset && !FlushE && (FDivReqE || IDivReqE);
    // rr_fp_q=1 favours FP on a collision
    assign pick_int = IDivReqE && (!FDivReqE || !rr_fp_q);

    fdivsqrt_itercount #(
        .BPC    (BPC),
        .XLEN   (XLEN),
        .LOGXLEN(LOGXLEN),
        .CNTW   (CNTW)
    ) u_itercount (
        .FmtE        (FmtE),
        .SpecialCaseE(SpecialCaseE),
        .IntnE       (IntnE),
        .IsInt       (pick_int),
        .NIter       (n_iter)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_fp_q     <= 1'b1;
            owner_int_q <= 1'b0;
            sqrt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_fp_q     <= rr_fp_d;
            owner_int_q <= owner_int_d;
            sqrt_q      <= sqrt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_fp_d     = rr_fp_q;
        owner_int_d = owner_int_q;
        sqrt_d      = sqrt_q;
        IFDivStartE = 1'b0;
        FDivBusyE   = 1'b0;
        FpGntE      = 1'b0;
        IntGntE     = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    IFDivStartE = 1'b1;
                    FDivBusyE   = 1'b1;
                    FpGntE      = !pick_int;
                    IntGntE     = pick_int;
                    owner_int_d = pick_int;
                    sqrt_d      = !pick_int && SqrtE;
                    cnt_d       = n_iter;
                    state_d     = (n_iter == '0) ? DONE : BUSY;
                    if (FDivReqE && IDivReqE) rr_fp_d = !rr_fp_q;
                end
            end
            BUSY: begin
                FDivBusyE = 1'b1;
                cnt_d     = cnt_q - CNTW'(1);
                if (cnt_q <= CNTW'(1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                if (ResultAckE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // flush wins over ack and over BUSY->DONE
        if (FlushE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign DivDoneM   = (state_q == DONE);
    assign DoneIsIntM = owner_int_q;
    assign DoneSqrtM  = sqrt_q;
    assign IterCnt    = cnt_q;

endmodule
